apb_requester: RTL and testbench

- APB requester (bus master) that sits directly upstream of the APB peripheral and drives the shared APB bus.
- Accepts one transfer at a time on a valid/ready command port.
- Sequences the transfer through the APB SETUP and ACCESS phases, honouring peripheral wait states.
- Returns read data and error status on a registered response port, with an optional timeout if PREADY never arrives.

---
 rtl/apb_requester.sv | 133 +++++++++++++
 tb/tb_apb_requester.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_requester.sv
// APB requester: accepts one command at a time, runs it through SETUP/ACCESS,
// and returns a one-cycle registered response with error and optional timeout.
module apb_requester #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int TIMEOUT    = 16
) (
  input  logic                  pclk,
  input  logic                  preset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  input  logic [STRB_WIDTH-1:0] cmd_strb,
  input  logic [2:0]            cmd_prot,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  rsp_timeout,
  output logic                  psel,
  output logic                  penable,
  output logic                  pwrite,
  output logic [ADDR_WIDTH-1:0] paddr,
  output logic [DATA_WIDTH-1:0] pwdata,
  output logic [STRB_WIDTH-1:0] pstrb,
  output logic [2:0]            pprot,
  input  logic [DATA_WIDTH-1:0] prdata,
  input  logic                  pready,
  input  logic                  pslverr
);

  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(STRB_WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             err_pend;
  logic             accept;
  logic             aligned;
  logic             load;

  // A misaligned command taken on a completing ACCESS leaves its error response
  // pending for one cycle; intake pauses until it has been issued.
  assign cmd_ready = (state == IDLE) ? !err_pend : ((state == ACCESS) && pready);
  assign accept    = cmd_valid && cmd_ready;
  assign aligned   = (cmd_addr & ALIGN_MASK) == '0;
  assign load      = accept && aligned;

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      pwrite <= 1'b0;
      paddr  <= '0;
      pwdata <= '0;
      pstrb  <= '0;
      pprot  <= '0;
    end else if (load) begin
      pwrite <= cmd_write;
      paddr  <= cmd_addr;
      pwdata <= cmd_wdata;
      pstrb  <= cmd_write ? cmd_strb : '0;
      pprot  <= cmd_prot;
    end
  end

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state       <= IDLE;
      psel        <= 1'b0;
      penable     <= 1'b0;
      cnt         <= '0;
      err_pend    <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
      rsp_rdata   <= '0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          psel    <= 1'b0;
          penable <= 1'b0;
          if (err_pend || (accept && !aligned)) begin
            err_pend    <= 1'b0;
            rsp_valid   <= 1'b1;
            rsp_err     <= 1'b1;
            rsp_timeout <= 1'b0;
            rsp_rdata   <= '0;
          end else if (load) begin
            psel  <= 1'b1;
            state <= SETUP;
          end
        end
        SETUP: begin
          penable <= 1'b1;
          cnt     <= '0;
          state   <= ACCESS;
        end
        ACCESS: begin
          if (pready) begin
            rsp_valid   <= 1'b1;
            rsp_err     <= pslverr;
            rsp_timeout <= 1'b0;
            if (!pwrite) rsp_rdata <= prdata;
            penable <= 1'b0;
            if (load) begin
              state <= SETUP;
            end else begin
              psel     <= 1'b0;
              state    <= IDLE;
              err_pend <= accept;
            end
          end else if ((TIMEOUT != 0) && (cnt == CNT_LAST)) begin
            psel        <= 1'b0;
            penable     <= 1'b0;
            rsp_valid   <= 1'b1;
            rsp_err     <= 1'b1;
            rsp_timeout <= 1'b1;
            state       <= IDLE;
          end else if (cnt != '1) begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_requester.sv
// Directed self-checking bench for apb_requester with hand-computed expectations.
module tb_apb_requester;

  logic        pclk;
  logic        preset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_strb;
  logic [2:0]  cmd_prot;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        rsp_timeout;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic [2:0]  pprot;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  int n_checks = 0;
  int n_errors = 0;

  apb_requester #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .TIMEOUT(16)
  ) dut (
    .pclk(pclk), .preset(preset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb), .cmd_prot(cmd_prot),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .pstrb(pstrb), .pprot(pprot), .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic set_cmd(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, input logic [2:0] p);
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = a;
    cmd_wdata = d;
    cmd_strb  = s;
    cmd_prot  = p;
  endtask

  task automatic chk_bus(input string tag, input logic sel, input logic en);
    chk({tag, ".psel"}, psel, sel);
    chk({tag, ".penable"}, penable, en);
  endtask

  task automatic chk_rsp(input string tag, input logic v, input logic e, input logic t);
    chk({tag, ".rsp_valid"}, rsp_valid, v);
    if (v) begin
      chk({tag, ".rsp_err"}, rsp_err, e);
      chk({tag, ".rsp_timeout"}, rsp_timeout, t);
    end
  endtask

  initial begin
    preset = 1'b1;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    cmd_strb = '0; cmd_prot = '0; prdata = '0; pready = 1'b0; pslverr = 1'b0;
    tick(); tick();
    chk_bus("reset", 1'b0, 1'b0);
    chk("reset.rsp_valid", rsp_valid, 1'b0);
    chk("reset.paddr", paddr, 32'h0);
    chk("reset.rsp_rdata", rsp_rdata, 32'h0);
    chk("reset.cmd_ready", cmd_ready, 1'b1);
    preset = 1'b0;
    tick();

    // 1: zero-wait write
    set_cmd(1'b1, 32'h4, 32'hDEADBEEF, 4'hF, 3'b101);
    pready = 1'b1;
    chk("wr.cmd_ready_idle", cmd_ready, 1'b1);
    tick();
    cmd_valid = 1'b0;
    chk_bus("wr.setup", 1'b1, 1'b0);
    chk("wr.cmd_ready_setup", cmd_ready, 1'b0);
    chk("wr.paddr", paddr, 32'h4);
    chk("wr.pwdata", pwdata, 32'hDEADBEEF);
    chk("wr.pstrb", pstrb, 4'hF);
    chk("wr.pwrite", pwrite, 1'b1);
    chk("wr.pprot", pprot, 3'b101);
    tick();
    chk_bus("wr.access", 1'b1, 1'b1);
    chk("wr.cmd_ready_access", cmd_ready, 1'b1);
    chk_rsp("wr.T2", 1'b0, 1'b0, 1'b0);
    tick();
    chk_bus("wr.done", 1'b0, 1'b0);
    chk_rsp("wr.T3", 1'b1, 1'b0, 1'b0);
    tick();
    chk_rsp("wr.T4", 1'b0, 1'b0, 1'b0);

    // 2: read with three wait states
    pready = 1'b0;
    set_cmd(1'b0, 32'h4, 32'h11112222, 4'hF, 3'b000);
    tick();
    cmd_valid = 1'b0;
    chk("rd.pstrb", pstrb, 4'h0);
    chk("rd.pwdata", pwdata, 32'h11112222);
    chk("rd.pwrite", pwrite, 1'b0);
    tick();
    for (int i = 0; i < 4; i++) begin
      chk_bus("rd.access", 1'b1, 1'b1);
      chk("rd.paddr_stable", paddr, 32'h4);
      chk_rsp("rd.wait", 1'b0, 1'b0, 1'b0);
      if (i == 3) begin
        pready = 1'b1;
        prdata = 32'hDEADBEEF;
      end else begin
        chk("rd.cmd_ready_wait", cmd_ready, 1'b0);
      end
      tick();
    end
    chk_rsp("rd.T6", 1'b1, 1'b0, 1'b0);
    chk("rd.rdata", rsp_rdata, 32'hDEADBEEF);
    chk_bus("rd.done", 1'b0, 1'b0);
    prdata = 32'h0;

    // 3: back-to-back write then read, cmd_valid held
    set_cmd(1'b1, 32'h8, 32'h12345678, 4'h3, 3'b000);
    tick();
    set_cmd(1'b0, 32'h8, 32'h0, 4'hF, 3'b000);
    chk("b2b.cmd_ready_setup", cmd_ready, 1'b0);
    tick();
    chk_bus("b2b.access1", 1'b1, 1'b1);
    chk("b2b.pwrite1", pwrite, 1'b1);
    chk("b2b.pstrb1", pstrb, 4'h3);
    tick();
    cmd_valid = 1'b0;
    prdata = 32'hCAFEF00D;
    chk_bus("b2b.setup2", 1'b1, 1'b0);
    chk("b2b.pwrite2", pwrite, 1'b0);
    chk("b2b.pstrb2", pstrb, 4'h0);
    chk_rsp("b2b.rsp1", 1'b1, 1'b0, 1'b0);
    tick();
    chk_bus("b2b.access2", 1'b1, 1'b1);
    chk_rsp("b2b.gap", 1'b0, 1'b0, 1'b0);
    tick();
    chk_rsp("b2b.rsp2", 1'b1, 1'b0, 1'b0);
    chk("b2b.rdata", rsp_rdata, 32'hCAFEF00D);
    chk_bus("b2b.done", 1'b0, 1'b0);

    // 4: misaligned from IDLE
    set_cmd(1'b0, 32'h6, 32'h0, 4'hF, 3'b000);
    tick();
    cmd_valid = 1'b0;
    chk_bus("mis.idle", 1'b0, 1'b0);
    chk_rsp("mis.rsp", 1'b1, 1'b1, 1'b0);
    chk("mis.rdata", rsp_rdata, 32'h0);
    tick();
    chk_rsp("mis.after", 1'b0, 1'b0, 1'b0);
    chk_bus("mis.after", 1'b0, 1'b0);

    // 4b: misaligned taken on a completing ACCESS
    set_cmd(1'b1, 32'h10, 32'hA5A5A5A5, 4'hF, 3'b000);
    tick();
    tick();
    set_cmd(1'b1, 32'h11, 32'h0, 4'hF, 3'b000);
    chk("mis2.cmd_ready", cmd_ready, 1'b1);
    tick();
    cmd_valid = 1'b0;
    chk_bus("mis2.idle", 1'b0, 1'b0);
    chk_rsp("mis2.rsp1", 1'b1, 1'b0, 1'b0);
    tick();
    chk_rsp("mis2.rsp2", 1'b1, 1'b1, 1'b0);
    chk_bus("mis2.nobus", 1'b0, 1'b0);
    tick();
    chk_rsp("mis2.after", 1'b0, 1'b0, 1'b0);

    // 5: slave error on a read
    pslverr = 1'b1;
    prdata = 32'h55AA55AA;
    set_cmd(1'b0, 32'h1C, 32'h0, 4'h0, 3'b010);
    tick();
    cmd_valid = 1'b0;
    tick();
    tick();
    chk_rsp("slverr", 1'b1, 1'b1, 1'b0);
    chk("slverr.rdata", rsp_rdata, 32'h55AA55AA);
    pslverr = 1'b0;

    // 6: timeout after 16 ACCESS cycles
    pready = 1'b0;
    set_cmd(1'b0, 32'h40, 32'h0, 4'h0, 3'b000);
    tick();
    cmd_valid = 1'b0;
    tick();
    for (int i = 0; i < 16; i++) begin
      chk_bus("to.access", 1'b1, 1'b1);
      chk_rsp("to.wait", 1'b0, 1'b0, 1'b0);
      tick();
    end
    chk_bus("to.abort", 1'b0, 1'b0);
    chk_rsp("to.rsp", 1'b1, 1'b1, 1'b1);
    tick();
    chk_bus("to.after", 1'b0, 1'b0);
    chk_rsp("to.after", 1'b0, 1'b0, 1'b0);

    // 7: reset during a waiting write, then a clean write
    set_cmd(1'b1, 32'h20, 32'hFEEDFACE, 4'hC, 3'b111);
    tick();
    cmd_valid = 1'b0;
    tick();
    tick();
    chk_bus("rst.pre", 1'b1, 1'b1);
    #2 preset = 1'b1;
    #1;
    chk_bus("rst.async", 1'b0, 1'b0);
    chk("rst.paddr", paddr, 32'h0);
    chk("rst.pwdata", pwdata, 32'h0);
    chk("rst.pstrb", pstrb, 4'h0);
    chk("rst.pprot", pprot, 3'h0);
    chk("rst.pwrite", pwrite, 1'b0);
    tick();
    chk("rst.rsp_valid", rsp_valid, 1'b0);
    preset = 1'b0;
    pready = 1'b1;
    tick();
    chk("rst.rsp_valid2", rsp_valid, 1'b0);
    set_cmd(1'b1, 32'h24, 32'h0BADF00D, 4'hF, 3'b000);
    tick();
    cmd_valid = 1'b0;
    chk_bus("post.setup", 1'b1, 1'b0);
    chk("post.paddr", paddr, 32'h24);
    tick();
    chk_bus("post.access", 1'b1, 1'b1);
    tick();
    chk_rsp("post.rsp", 1'b1, 1'b0, 1'b0);
    tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
